// File: rtl/msg_key_loader.sv
// Command-framed loader: assembles a 64-bit message and/or key from a byte stream and
// commits them atomically; an inter-byte timeout aborts partial frames.
module msg_key_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_MSG        = 8'hA5,
    parameter logic [7:0]  CMD_KEY        = 8'h5A,
    parameter logic [7:0]  CMD_BOTH       = 8'hC3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [63:0] msg,
    output logic [63:0] key,
    output logic        msg_loaded,
    output logic        key_loaded,
    output logic        load_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRxMsg, StRxKey} state_e;
    typedef enum logic [1:0] {ModeMsg, ModeKey, ModeBoth} mode_e;

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [2:0]    byte_cnt_q;
    logic [TW-1:0] tmo_q;
    logic [63:0]   msg_shadow_q;
    // Key always commits together with its final byte, so only 7 bytes need holding.
    logic [55:0]   key_shadow_q;

    logic start, shift_msg, shift_key, to_key, commit_msg, commit_key, abort;
    logic last_byte, tmo_hit;

    assign last_byte = (byte_cnt_q == 3'd7);
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        start      = 1'b0;
        shift_msg  = 1'b0;
        shift_key  = 1'b0;
        to_key     = 1'b0;
        commit_msg = 1'b0;
        commit_key = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == CMD_MSG) begin
                        state_d = StRxMsg;
                        mode_d  = ModeMsg;
                        start   = 1'b1;
                    end else if (rx_data == CMD_BOTH) begin
                        state_d = StRxMsg;
                        mode_d  = ModeBoth;
                        start   = 1'b1;
                    end else if (rx_data == CMD_KEY) begin
                        state_d = StRxKey;
                        mode_d  = ModeKey;
                        start   = 1'b1;
                    end
                end
            end
            StRxMsg: begin
                if (rx_valid) begin
                    shift_msg = 1'b1;
                    if (last_byte) begin
                        if (mode_q == ModeBoth) begin
                            state_d = StRxKey;
                            to_key  = 1'b1;
                        end else begin
                            state_d    = StIdle;
                            commit_msg = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    abort   = 1'b1;
                end
            end
            StRxKey: begin
                if (rx_valid) begin
                    shift_key = 1'b1;
                    if (last_byte) begin
                        state_d    = StIdle;
                        commit_key = 1'b1;
                        commit_msg = (mode_q == ModeBoth);
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    abort   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= ModeMsg;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            msg_shadow_q <= '0;
            key_shadow_q <= '0;
            msg          <= '0;
            key          <= '0;
            msg_loaded   <= 1'b0;
            key_loaded   <= 1'b0;
            load_done    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            load_done <= commit_msg | commit_key;
            frame_err <= abort;

            if (start || shift_msg || shift_key || state_d == StIdle) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (start || to_key || state_d == StIdle) begin
                byte_cnt_q <= '0;
            end else if (shift_msg || shift_key) begin
                byte_cnt_q <= byte_cnt_q + 3'd1;
            end

            if (abort) begin
                msg_shadow_q <= '0;
                key_shadow_q <= '0;
            end else begin
                if (shift_msg) msg_shadow_q <= {msg_shadow_q[55:0], rx_data};
                if (shift_key) key_shadow_q <= {key_shadow_q[47:0], rx_data};
            end

            // In a BOTH frame the message commits from the shadow on the key's final byte.
            if (commit_msg) begin
                msg        <= shift_msg ? {msg_shadow_q[55:0], rx_data} : msg_shadow_q;
                msg_loaded <= 1'b1;
            end
            if (commit_key) begin
                key        <= {key_shadow_q, rx_data};
                key_loaded <= 1'b1;
            end
        end
    end

endmodule
